memory_access_stage: RTL and testbench
======================================

# memory_access_stage

Pipeline MEM stage that sits directly downstream of the EX/MEM register. It takes the executed instruction's ALU result, store data and control bits and, for loads and stores, runs a request/ready handshake with the data cache. While an access is in flight it stalls the upstream stages. When the access completes it pulses `unlock`, then presents a registered writeback bundle to the MEM/WB register and register file.

## Interface
- `WORD_WIDTH`, 32, data/address width
- `REGISTER_INDEX_WIDTH`, 5, destination register index width

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous reset, active-high
- `active_in`  in  1  EX/MEM slot holds a valid instruction
- `instruction_in`  in  WORD_WIDTH  instruction word (carried for debug/WB)
- `alu_result_in`  in  WORD_WIDTH  ALU result; the memory address for accesses
- `second_input_in`  in  WORD_WIDTH  store data
- `cu_mem_to_reg_in`  in  1  load result goes to the register file
- `cu_reg_write_in`  in  1  instruction writes a register
- `destination_register_in`  in  REGISTER_INDEX_WIDTH  rd
- `cu_d_cache_access_in`  in  1  instruction accesses memory
- `cu_d_cache_op_in`  in  1  0 = load, 1 = store
- `cu_is_byte_op_in`  in  1  byte access (lb/sb)
- `d_cache_req`  out  1  request valid to the data cache
- `d_cache_op`  out  1  0 = read, 1 = write
- `d_cache_addr`  out  WORD_WIDTH  access address
- `d_cache_wdata`  out  WORD_WIDTH  write data
- `d_cache_byte`  out  1  byte-granular access
- `d_cache_ready`  in  1  cache completed the request (one-cycle pulse)
- `d_cache_rdata`  in  WORD_WIDTH  read word, valid while `d_cache_ready`
- `stall_out`  out  1  combinational; freeze upstream stages
- `unlock`  out  1  one-cycle pulse; the access has finished
- `wb_active_out`  out  1  WB bundle valid
- `wb_reg_write_out`  out  1  write rd
- `wb_destination_register_out`  out  REGISTER_INDEX_WIDTH  rd
- `wb_data_out`  out  WORD_WIDTH  value to write
- `wb_instruction_out`  out  WORD_WIDTH  instruction word

## Operation
- States:
  - IDLE: no access outstanding.
  - WAIT: request outstanding.
- IDLE, `active_in=1`, `cu_d_cache_access_in=0`:
  - Next cycle `wb_active_out=1`.
  - `wb_data_out=alu_result_in`.
  - `wb_reg_write_out=cu_reg_write_in`.
  - `wb_destination_register_out` and `wb_instruction_out` are copied from their inputs.
- IDLE, `active_in=1`, `cu_d_cache_access_in=1`:
  - Latch op, byte flag, address, store data, rd, reg_write and mem_to_reg.
  - Go to WAIT and assert `d_cache_req` from the next cycle.
  - `wb_active_out=0` next cycle.
- Address rule:
  - Byte access: `d_cache_addr` = address unmodified.
  - Word access: bits [1:0] forced to 0.
- `d_cache_wdata` = latched store data; the cache selects the byte lane.
- WAIT:
  - Hold `d_cache_req` and all request fields stable until `d_cache_ready`.
  - On `d_cache_ready`, go to IDLE. On the next cycle:
    - `d_cache_req=0`, `unlock=1`, `wb_active_out=1`.
    - Load with mem_to_reg: `wb_data_out` = aligned load data.
    - Store: `wb_reg_write_out=0`.
- Load alignment:
  - Word load: rdata as is.
  - Byte load: lane `addr[1:0]`, little-endian (lane 0 = bits [7:0]), sign-extended to WORD_WIDTH.
- `stall_out` = (state==WAIT) | (state==IDLE & active_in & cu_d_cache_access_in).
- IDLE, `active_in=0`: `wb_active_out=0` next cycle; the other wb fields hold.

## Timing
- Reset values: all outputs 0 and state IDLE.
- Reset is applied mid-access:
  - `d_cache_req` drops next cycle.
  - No `unlock` pulse and no WB.
  - A cache `d_cache_ready` that arrives after reset is ignored.
- Latency:
  - Non-memory instruction: 1 cycle.
  - Memory instruction: 1 + N cycles, where N ≥ 1 is the number of cycles from the first `d_cache_req` high to `d_cache_ready`. The minimum is 2.
- `d_cache_ready` is accepted in the first cycle `d_cache_req` is high.
- `d_cache_ready` while in IDLE is ignored.
- `active_in` while in WAIT is ignored; upstream is held by `stall_out`.
- Back-to-back accesses:
  - The cycle that pulses `unlock` also samples the next input in IDLE.
  - A new access can therefore raise `d_cache_req` in the following cycle, with no bubble beyond handshake cost.
- `unlock` is never high for more than one consecutive cycle.

## Structure
- Shared package holds:
  - State encoding (IDLE, WAIT).
  - Op encoding (`MEM_OP_LOAD=0`, `MEM_OP_STORE=1`).
  - `WORD_WIDTH` and `REGISTER_INDEX_WIDTH` defaults.
- Sub-module `load_aligner`: combinational byte-lane select plus sign extension. Inputs: rdata, addr[1:0], byte flag.
- The top level holds the FSM, request latches and WB registers.

## Test plan
- ALU op: active, access=0, alu_result=0x0000_1234, rd=5, reg_write=1 → next cycle `wb_active=1`, `wb_data=0x1234`, rd=5; `stall_out` never high.
- Word load: addr 0x0000_0103, cache ready 3 cycles after req with rdata=0xDEAD_BEEF:
  - `d_cache_addr=0x100`.
  - `stall_out` high for 4 cycles.
  - `unlock` single pulse.
  - `wb_data=0xDEAD_BEEF`.
- Byte load: addr 0x0000_0202, rdata=0x1280_3456 → `d_cache_byte=1`, `wb_data=0xFFFF_FF80`.
- Store: data 0xCAFE_0001, ready in the first req cycle:
  - `d_cache_op=1`.
  - `unlock` in the cycle after ready.
  - `wb_active=1`, `wb_reg_write=0`.
  - Total latency 2.
- Reset asserted in WAIT:
  - `d_cache_req=0` next cycle.
  - A later `d_cache_ready` produces no `unlock` or WB.
  - All outputs are 0.

Source files
------------

// File: rtl/memory_access_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage.
package memory_access_stage_pkg;

    localparam int DEFAULT_WORD_WIDTH           = 32;
    localparam int DEFAULT_REGISTER_INDEX_WIDTH = 5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

    localparam logic MEM_OP_LOAD  = 1'b0;
    localparam logic MEM_OP_STORE = 1'b1;

endpackage

// File: rtl/memory_access_stage_load_aligner.sv
// Picks the addressed byte lane out of a cache read word and sign-extends it
// for byte loads; word loads pass through untouched.
module load_aligner
    import memory_access_stage_pkg::*;
#(
    parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH
) (
    input  logic [WORD_WIDTH-1:0] rdata,
    input  logic [1:0]            byte_lane,
    input  logic                  is_byte,
    output logic [WORD_WIDTH-1:0] aligned_data
);

    logic [7:0] lane_byte;

    // Little-endian lanes: lane 0 is the least significant byte.
    always_comb begin
        lane_byte = rdata[7:0];
        unique case (byte_lane)
            2'd0: lane_byte = rdata[7:0];
            2'd1: lane_byte = rdata[15:8];
            2'd2: lane_byte = rdata[23:16];
            2'd3: lane_byte = rdata[31:24];
            default: lane_byte = rdata[7:0];
        endcase
    end

    always_comb begin
        if (is_byte) begin
            aligned_data = {{(WORD_WIDTH-8){lane_byte[7]}}, lane_byte};
        end else begin
            aligned_data = rdata;
        end
    end

endmodule

// File: rtl/memory_access_stage.sv
// MEM pipeline stage: runs the data-cache handshake for loads and stores,
// stalls upstream while an access is outstanding and registers the WB bundle.
module memory_access_stage
    import memory_access_stage_pkg::*;
#(
    parameter int WORD_WIDTH           = DEFAULT_WORD_WIDTH,
    parameter int REGISTER_INDEX_WIDTH = DEFAULT_REGISTER_INDEX_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            active_in,
    input  logic [WORD_WIDTH-1:0]           instruction_in,
    input  logic [WORD_WIDTH-1:0]           alu_result_in,
    input  logic [WORD_WIDTH-1:0]           second_input_in,
    input  logic                            cu_mem_to_reg_in,
    input  logic                            cu_reg_write_in,
    input  logic [REGISTER_INDEX_WIDTH-1:0] destination_register_in,
    input  logic                            cu_d_cache_access_in,
    input  logic                            cu_d_cache_op_in,
    input  logic                            cu_is_byte_op_in,
    output logic                            d_cache_req,
    output logic                            d_cache_op,
    output logic [WORD_WIDTH-1:0]           d_cache_addr,
    output logic [WORD_WIDTH-1:0]           d_cache_wdata,
    output logic                            d_cache_byte,
    input  logic                            d_cache_ready,
    input  logic [WORD_WIDTH-1:0]           d_cache_rdata,
    output logic                            stall_out,
    output logic                            unlock,
    output logic                            wb_active_out,
    output logic                            wb_reg_write_out,
    output logic [REGISTER_INDEX_WIDTH-1:0] wb_destination_register_out,
    output logic [WORD_WIDTH-1:0]           wb_data_out,
    output logic [WORD_WIDTH-1:0]           wb_instruction_out
);

    mem_state_e state_q, state_d;

    logic                            req_op_q, req_op_d;
    logic                            req_byte_q, req_byte_d;
    logic [WORD_WIDTH-1:0]           req_addr_q, req_addr_d;
    logic [WORD_WIDTH-1:0]           req_wdata_q, req_wdata_d;
    logic [REGISTER_INDEX_WIDTH-1:0] req_rd_q, req_rd_d;
    logic                            req_reg_write_q, req_reg_write_d;
    logic                            req_mem_to_reg_q, req_mem_to_reg_d;
    logic [WORD_WIDTH-1:0]           req_instr_q, req_instr_d;

    logic                            wb_active_q, wb_active_d;
    logic                            wb_reg_write_q, wb_reg_write_d;
    logic [REGISTER_INDEX_WIDTH-1:0] wb_rd_q, wb_rd_d;
    logic [WORD_WIDTH-1:0]           wb_data_q, wb_data_d;
    logic [WORD_WIDTH-1:0]           wb_instr_q, wb_instr_d;
    logic                            unlock_q, unlock_d;

    logic                            accept_access;
    logic [WORD_WIDTH-1:0]           load_data;

    assign accept_access = (state_q == ST_IDLE) && active_in && cu_d_cache_access_in;

    load_aligner #(
        .WORD_WIDTH(WORD_WIDTH)
    ) u_load_aligner (
        .rdata       (d_cache_rdata),
        .byte_lane   (req_addr_q[1:0]),
        .is_byte     (req_byte_q),
        .aligned_data(load_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept_access) state_d = ST_WAIT;
            ST_WAIT: if (d_cache_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Request fields come straight from the latches so they stay stable in WAIT.
    always_comb begin
        d_cache_req   = (state_q == ST_WAIT);
        stall_out     = (state_q == ST_WAIT) || accept_access;
        d_cache_op    = req_op_q;
        d_cache_byte  = req_byte_q;
        d_cache_wdata = req_wdata_q;
        d_cache_addr  = req_byte_q ? req_addr_q : {req_addr_q[WORD_WIDTH-1:2], 2'b00};
    end

    always_comb begin
        req_op_d         = req_op_q;
        req_byte_d       = req_byte_q;
        req_addr_d       = req_addr_q;
        req_wdata_d      = req_wdata_q;
        req_rd_d         = req_rd_q;
        req_reg_write_d  = req_reg_write_q;
        req_mem_to_reg_d = req_mem_to_reg_q;
        req_instr_d      = req_instr_q;
        wb_active_d      = 1'b0;
        wb_reg_write_d   = wb_reg_write_q;
        wb_rd_d          = wb_rd_q;
        wb_data_d        = wb_data_q;
        wb_instr_d       = wb_instr_q;
        unlock_d         = 1'b0;

        if (state_q == ST_IDLE) begin
            if (active_in && !cu_d_cache_access_in) begin
                wb_active_d    = 1'b1;
                wb_reg_write_d = cu_reg_write_in;
                wb_rd_d        = destination_register_in;
                wb_data_d      = alu_result_in;
                wb_instr_d     = instruction_in;
            end
            if (accept_access) begin
                req_op_d         = cu_d_cache_op_in;
                req_byte_d       = cu_is_byte_op_in;
                req_addr_d       = alu_result_in;
                req_wdata_d      = second_input_in;
                req_rd_d         = destination_register_in;
                req_reg_write_d  = cu_reg_write_in;
                req_mem_to_reg_d = cu_mem_to_reg_in;
                req_instr_d      = instruction_in;
            end
        end else if (d_cache_ready) begin
            unlock_d       = 1'b1;
            wb_active_d    = 1'b1;
            wb_reg_write_d = (req_op_q == MEM_OP_STORE) ? 1'b0 : req_reg_write_q;
            wb_rd_d        = req_rd_q;
            wb_instr_d     = req_instr_q;
            wb_data_d      = (req_op_q == MEM_OP_LOAD && req_mem_to_reg_q) ? load_data : req_addr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_op_q         <= MEM_OP_LOAD;
            req_byte_q       <= 1'b0;
            req_addr_q       <= '0;
            req_wdata_q      <= '0;
            req_rd_q         <= '0;
            req_reg_write_q  <= 1'b0;
            req_mem_to_reg_q <= 1'b0;
            req_instr_q      <= '0;
            wb_active_q      <= 1'b0;
            wb_reg_write_q   <= 1'b0;
            wb_rd_q          <= '0;
            wb_data_q        <= '0;
            wb_instr_q       <= '0;
            unlock_q         <= 1'b0;
        end else begin
            req_op_q         <= req_op_d;
            req_byte_q       <= req_byte_d;
            req_addr_q       <= req_addr_d;
            req_wdata_q      <= req_wdata_d;
            req_rd_q         <= req_rd_d;
            req_reg_write_q  <= req_reg_write_d;
            req_mem_to_reg_q <= req_mem_to_reg_d;
            req_instr_q      <= req_instr_d;
            wb_active_q      <= wb_active_d;
            wb_reg_write_q   <= wb_reg_write_d;
            wb_rd_q          <= wb_rd_d;
            wb_data_q        <= wb_data_d;
            wb_instr_q       <= wb_instr_d;
            unlock_q         <= unlock_d;
        end
    end

    assign unlock                      = unlock_q;
    assign wb_active_out               = wb_active_q;
    assign wb_reg_write_out            = wb_reg_write_q;
    assign wb_destination_register_out = wb_rd_q;
    assign wb_data_out                 = wb_data_q;
    assign wb_instruction_out          = wb_instr_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage with a WB scoreboard fed by the
// stimulus tasks and drained by an independent monitor.
module tb_memory_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        active_in;
    logic [31:0] instruction_in;
    logic [31:0] alu_result_in;
    logic [31:0] second_input_in;
    logic        cu_mem_to_reg_in;
    logic        cu_reg_write_in;
    logic [4:0]  destination_register_in;
    logic        cu_d_cache_access_in;
    logic        cu_d_cache_op_in;
    logic        cu_is_byte_op_in;
    logic        d_cache_req;
    logic        d_cache_op;
    logic [31:0] d_cache_addr;
    logic [31:0] d_cache_wdata;
    logic        d_cache_byte;
    logic        d_cache_ready;
    logic [31:0] d_cache_rdata;
    logic        stall_out;
    logic        unlock;
    logic        wb_active_out;
    logic        wb_reg_write_out;
    logic [4:0]  wb_destination_register_out;
    logic [31:0] wb_data_out;
    logic [31:0] wb_instruction_out;

    typedef struct {
        logic        reg_write;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        check_data;
        logic [31:0] instr;
    } wb_exp_t;

    wb_exp_t exp_q[$];
    int      tests_run    = 0;
    int      tests_failed = 0;

    memory_access_stage dut (
        .clk                        (clk),
        .rst                        (rst),
        .active_in                  (active_in),
        .instruction_in             (instruction_in),
        .alu_result_in              (alu_result_in),
        .second_input_in            (second_input_in),
        .cu_mem_to_reg_in           (cu_mem_to_reg_in),
        .cu_reg_write_in            (cu_reg_write_in),
        .destination_register_in    (destination_register_in),
        .cu_d_cache_access_in       (cu_d_cache_access_in),
        .cu_d_cache_op_in           (cu_d_cache_op_in),
        .cu_is_byte_op_in           (cu_is_byte_op_in),
        .d_cache_req                (d_cache_req),
        .d_cache_op                 (d_cache_op),
        .d_cache_addr               (d_cache_addr),
        .d_cache_wdata              (d_cache_wdata),
        .d_cache_byte               (d_cache_byte),
        .d_cache_ready              (d_cache_ready),
        .d_cache_rdata              (d_cache_rdata),
        .stall_out                  (stall_out),
        .unlock                     (unlock),
        .wb_active_out              (wb_active_out),
        .wb_reg_write_out           (wb_reg_write_out),
        .wb_destination_register_out(wb_destination_register_out),
        .wb_data_out                (wb_data_out),
        .wb_instruction_out         (wb_instruction_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_req"}, 32'(d_cache_req), 32'd0);
        checkOutput({tag, "_addr"}, d_cache_addr, 32'd0);
        checkOutput({tag, "_wdata"}, d_cache_wdata, 32'd0);
        checkOutput({tag, "_unlock"}, 32'(unlock), 32'd0);
        checkOutput({tag, "_wb_active"}, 32'(wb_active_out), 32'd0);
        checkOutput({tag, "_wb_data"}, wb_data_out, 32'd0);
        checkOutput({tag, "_wb_rd"}, 32'(wb_destination_register_out), 32'd0);
        checkOutput({tag, "_stall"}, 32'(stall_out), 32'd0);
    endtask

    // Called right after a falling edge; returns at the falling edge where WB is visible.
    task automatic applyStimulus(input logic access, input logic op, input logic byte_f,
                                 input logic [31:0] addr, input logic [31:0] sdata,
                                 input logic [4:0] rd, input logic reg_write, input logic mem_to_reg,
                                 input logic [31:0] instr, input int latency,
                                 input logic [31:0] rdata, input logic [31:0] exp_addr,
                                 input logic exp_reg_write, input logic check_data,
                                 input logic [31:0] exp_data);
        wb_exp_t e;
        int stall_cycles;
        e.reg_write = exp_reg_write; e.rd = rd; e.data = exp_data;
        e.check_data = check_data; e.instr = instr;
        exp_q.push_back(e);

        active_in = 1'b1; cu_d_cache_access_in = access; cu_d_cache_op_in = op;
        cu_is_byte_op_in = byte_f; alu_result_in = addr; second_input_in = sdata;
        destination_register_in = rd; cu_reg_write_in = reg_write;
        cu_mem_to_reg_in = mem_to_reg; instruction_in = instr;
        #1;
        checkOutput("stall_on_issue", 32'(stall_out), 32'(access));
        @(posedge clk);
        @(negedge clk);
        active_in = 1'b0; cu_d_cache_access_in = 1'b0;
        if (!access) begin
            checkOutput("alu_wb_latency", 32'(wb_active_out), 32'd1);
            checkOutput("alu_no_req", 32'(d_cache_req), 32'd0);
        end else begin
            checkOutput("req_addr", d_cache_addr, exp_addr);
            checkOutput("req_op", 32'(d_cache_op), 32'(op));
            checkOutput("req_byte", 32'(d_cache_byte), 32'(byte_f));
            checkOutput("req_wdata", d_cache_wdata, sdata);
            stall_cycles = 1;
            for (int k = 1; k <= latency; k++) begin
                if (k > 1) @(negedge clk);
                checkOutput("req_held", 32'(d_cache_req), 32'd1);
                checkOutput("no_unlock_in_wait", 32'(unlock), 32'd0);
                checkOutput("no_wb_in_wait", 32'(wb_active_out), 32'd0);
                if (stall_out) stall_cycles++;
                if (k == latency) begin
                    d_cache_ready = 1'b1;
                    d_cache_rdata = rdata;
                end
                @(posedge clk);
            end
            @(negedge clk);
            d_cache_ready = 1'b0;
            d_cache_rdata = 32'h0;
            checkOutput("unlock_pulse", 32'(unlock), 32'd1);
            checkOutput("req_dropped", 32'(d_cache_req), 32'd0);
            checkOutput("mem_wb_latency", 32'(wb_active_out), 32'd1);
            checkOutput("stall_cycles", 32'(stall_cycles), 32'(latency + 1));
        end
    endtask

    // Scoreboard monitor: pops one expectation per valid WB bundle.
    always @(negedge clk) begin
        if (!rst && wb_active_out) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_wb", 32'(wb_active_out), 32'd0);
            end else begin
                wb_exp_t e;
                e = exp_q.pop_front();
                checkOutput("wb_reg_write", 32'(wb_reg_write_out), 32'(e.reg_write));
                checkOutput("wb_rd", 32'(wb_destination_register_out), 32'(e.rd));
                checkOutput("wb_instr", wb_instruction_out, e.instr);
                if (e.check_data) checkOutput("wb_data", wb_data_out, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; active_in = 1'b0; instruction_in = '0; alu_result_in = '0;
        second_input_in = '0; cu_mem_to_reg_in = 1'b0; cu_reg_write_in = 1'b0;
        destination_register_in = '0; cu_d_cache_access_in = 1'b0; cu_d_cache_op_in = 1'b0;
        cu_is_byte_op_in = 1'b0; d_cache_ready = 1'b0; d_cache_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkAllZero("reset");
        rst = 1'b0;
        @(negedge clk);

        // ALU op, word load, byte load, store
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 1'b0, 32'h00A0_0293,
                      0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0000_1234);
        @(negedge clk);
        checkOutput("wb_drops_when_idle", 32'(wb_active_out), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_0103, 32'h0, 5'd6, 1'b1, 1'b1, 32'h1030_2303,
                      3, 32'hDEAD_BEEF, 32'h0000_0100, 1'b1, 1'b1, 32'hDEAD_BEEF);
        @(negedge clk);
        checkOutput("unlock_single", 32'(unlock), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0202, 32'h0, 5'd7, 1'b1, 1'b1, 32'h2020_0383,
                      2, 32'h1280_3456, 32'h0000_0202, 1'b1, 1'b1, 32'hFFFF_FF80);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'hCAFE_0001, 5'd9, 1'b1, 1'b0, 32'h04A0_2023,
                      1, 32'h0, 32'h0000_0040, 1'b0, 1'b0, 32'h0);

        // Back-to-back: next accesses issued in the unlock cycle
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0011, 32'h0, 5'd10, 1'b1, 1'b1, 32'h0110_0503,
                      1, 32'h0000_7F00, 32'h0000_0011, 1'b1, 1'b1, 32'h0000_007F);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0007, 32'h0, 5'd11, 1'b1, 1'b1, 32'h0070_0583,
                      2, 32'hA500_0000, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFA5);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0004, 32'h0, 5'd12, 1'b1, 1'b1, 32'h0040_0603,
                      1, 32'hFFFF_FF07, 32'h0000_0004, 1'b1, 1'b1, 32'h0000_0007);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'hFFFF_0000, 32'h0, 5'd31, 1'b0, 1'b0, 32'h0000_0FB3,
                      0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hFFFF_0000);
        @(negedge clk);

        // Reset in WAIT, then a stray ready that must be ignored
        active_in = 1'b1; cu_d_cache_access_in = 1'b1; cu_d_cache_op_in = 1'b0;
        cu_is_byte_op_in = 1'b0; alu_result_in = 32'h0000_0300; destination_register_in = 5'd3;
        cu_reg_write_in = 1'b1; cu_mem_to_reg_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        active_in = 1'b0; cu_d_cache_access_in = 1'b0;
        checkOutput("pre_reset_req", 32'(d_cache_req), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkAllZero("mid_reset");
        d_cache_ready = 1'b1; d_cache_rdata = 32'h5555_5555;
        @(posedge clk);
        @(negedge clk);
        d_cache_ready = 1'b0;
        checkOutput("stray_ready_unlock", 32'(unlock), 32'd0);
        checkOutput("stray_ready_wb", 32'(wb_active_out), 32'd0);
        checkOutput("stray_ready_req", 32'(d_cache_req), 32'd0);
        @(negedge clk);
        checkOutput("stray_ready_unlock_late", 32'(unlock), 32'd0);
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
